// File: rtl/mmc5_scanline_irq_pkg.sv
// Shared register addresses, status bit positions and the nametable-space test
// used by the MMC5 scanline IRQ unit.
package mmc5_scanline_irq_pkg;

  localparam logic [15:0] MMC5_IRQ_TGT  = 16'h5203;
  localparam logic [15:0] MMC5_IRQ_STAT = 16'h5204;

  localparam int STAT_PEND = 7;
  localparam int STAT_INF  = 6;

  localparam logic [1:0] NT_SPACE = 2'b10;

  function automatic logic is_nt(input logic [13:0] addr);
    return addr[13:12] == NT_SPACE;
  endfunction

endpackage

// File: rtl/mmc5_nt_match.sv
// Nametable-fetch repeat detector: pulses evt on the third consecutive identical
// nametable read, then restarts its run count.
module mmc5_nt_match
  import mmc5_scanline_irq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        rd_stb,
  input  logic [13:0] addr,
  output logic        evt
);

  logic [13:0] last_addr;
  logic [1:0]  match_cnt;
  logic        hit;

  // match_cnt is the length of the current run of identical NT reads, so a
  // fresh NT address starts the run at 1 and the third read fires.
  assign hit = is_nt(addr) && (addr == last_addr);
  assign evt = rd_stb && hit && (match_cnt == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr <= '0;
      match_cnt <= '0;
    end else if (rd_stb) begin
      last_addr <= addr;
      if (!hit) begin
        match_cnt <= is_nt(addr) ? 2'd1 : 2'd0;
      end else if (match_cnt == 2'd2) begin
        match_cnt <= 2'd0;
      end else begin
        match_cnt <= match_cnt + 2'd1;
      end
    end else if (clr) begin
      match_cnt <= '0;
    end
  end

endmodule

// File: rtl/mmc5_scanline_irq.sv
// MMC5 in-frame / scanline detector and scanline IRQ with the $5203/$5204 registers.
// All inputs are single-clk strobes: a strobe high for one clk is one transaction, no back-pressure.
module mmc5_scanline_irq
  import mmc5_scanline_irq_pkg::*;
#(
  parameter int IDLE_LIM = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             map_rst,
  input  logic             ppu_rd_stb,
  input  logic [13:0]      ppu_addr,
  input  logic             cpu_cyc_stb,
  input  logic             cpu_wr_stb,
  input  logic             cpu_rd_stb,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_dat,
  output logic             irq,
  output logic             stat_oe,
  output logic [7:0]       stat_dat,
  output logic             in_frame,
  output logic [CNT_W-1:0] scanline
);

  localparam int IDLE_W = $clog2(IDLE_LIM + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic [CNT_W-1:0]  irq_tgt;
  logic [CNT_W-1:0]  scan_q;
  logic [CNT_W-1:0]  scan_inc;
  logic              irq_en;
  logic              irq_pend;
  logic              in_frame_q;
  logic              sl_evt;
  logic              timeout;
  logic              stat_rd;
  logic              tgt_hit;

  // A PPU read in the same clk clears the idle count, so it also blocks the timeout.
  assign timeout  = cpu_cyc_stb && !ppu_rd_stb && (idle_cnt >= IDLE_W'(IDLE_LIM - 1));
  assign scan_inc = scan_q + CNT_W'(1);
  assign tgt_hit  = (irq_tgt != '0) && (scan_inc == irq_tgt);
  assign stat_rd  = cpu_rd_stb && (cpu_addr == MMC5_IRQ_STAT);

  mmc5_nt_match u_match (
    .clk    (clk),
    .rst    (map_rst),
    .clr    (timeout),
    .rd_stb (ppu_rd_stb),
    .addr   (ppu_addr),
    .evt    (sl_evt)
  );

  always_ff @(posedge clk) begin
    if (map_rst) begin
      idle_cnt   <= '0;
      irq_tgt    <= '0;
      irq_en     <= 1'b0;
      irq_pend   <= 1'b0;
      in_frame_q <= 1'b0;
      scan_q     <= '0;
    end else begin
      if (ppu_rd_stb) begin
        idle_cnt <= '0;
      end else if (cpu_cyc_stb && (idle_cnt != IDLE_W'(IDLE_LIM))) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
      if (cpu_wr_stb && (cpu_addr == MMC5_IRQ_TGT)) begin
        irq_tgt <= CNT_W'(cpu_dat);
      end
      if (cpu_wr_stb && (cpu_addr == MMC5_IRQ_STAT)) begin
        irq_en <= cpu_dat[7];
      end
      if (stat_rd) begin
        irq_pend <= 1'b0;
      end
      if (timeout) begin
        in_frame_q <= 1'b0;
      end
      // Later assignments win: a pending-set beats a same-clk read-clear.
      if (sl_evt) begin
        if (!in_frame_q) begin
          in_frame_q <= 1'b1;
          scan_q     <= '0;
          irq_pend   <= 1'b0;
        end else begin
          scan_q <= scan_inc;
          if (tgt_hit) begin
            irq_pend <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    stat_dat            = '0;
    stat_dat[STAT_PEND] = irq_pend;
    stat_dat[STAT_INF]  = in_frame_q;
  end

  assign irq      = irq_pend & irq_en;
  assign stat_oe  = (cpu_addr == MMC5_IRQ_STAT);
  assign in_frame = in_frame_q;
  assign scanline = scan_q;

endmodule

// File: tb/tb_mmc5_scanline_irq.sv
// Bench for mmc5_scanline_irq: directed scenarios plus randomized strobes checked
// against a run-length / counter reference model.
module tb_mmc5_scanline_irq;

  logic        clk;
  logic        map_rst;
  logic        ppu_rd_stb;
  logic [13:0] ppu_addr;
  logic        cpu_cyc_stb;
  logic        cpu_wr_stb;
  logic        cpu_rd_stb;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        irq;
  logic        stat_oe;
  logic [7:0]  stat_dat;
  logic        in_frame;
  logic [7:0]  scanline;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  last_rd_dat;

  // reference model state
  logic [13:0] m_last;
  int          m_run;
  int          m_idle;
  bit          m_in_frame;
  int          m_scan;
  int          m_tgt;
  bit          m_en;
  bit          m_pend;

  logic [13:0] pool [0:5];
  logic        r_p, r_cyc, r_wr, r_rd, r_rst;
  logic [13:0] r_pa;
  logic [15:0] r_ca;
  logic [7:0]  r_d;
  int          r_kind;
  int          r_busy;

  mmc5_scanline_irq #(.IDLE_LIM(3), .CNT_W(8)) dut (
    .clk         (clk),
    .map_rst     (map_rst),
    .ppu_rd_stb  (ppu_rd_stb),
    .ppu_addr    (ppu_addr),
    .cpu_cyc_stb (cpu_cyc_stb),
    .cpu_wr_stb  (cpu_wr_stb),
    .cpu_rd_stb  (cpu_rd_stb),
    .cpu_addr    (cpu_addr),
    .cpu_dat     (cpu_dat),
    .irq         (irq),
    .stat_oe     (stat_oe),
    .stat_dat    (stat_dat),
    .in_frame    (in_frame),
    .scanline    (scanline)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_stat();
    return {m_pend, m_in_frame, 6'b0};
  endfunction

  task automatic model_step(input logic p, input logic [13:0] pa, input logic cyc,
                            input logic wr, input logic rd, input logic [15:0] ca,
                            input logic [7:0] d, input logic rst);
    bit evt;
    bit nt;
    int old_tgt;
    evt = 0;
    old_tgt = m_tgt;
    if (rst) begin
      m_last = '0; m_run = 0; m_idle = 0; m_in_frame = 0;
      m_scan = 0; m_tgt = 0; m_en = 0; m_pend = 0;
      return;
    end
    if (p) begin
      nt = (pa >= 14'h2000) && (pa <= 14'h2FFF);
      if (nt && (pa == m_last)) m_run++;
      else m_run = nt ? 1 : 0;
      m_last = pa;
      if (m_run == 3) begin
        evt = 1;
        m_run = 0;
      end
      m_idle = 0;
    end else if (cyc) begin
      m_idle++;
      if (m_idle >= 3) begin
        m_in_frame = 0;
        m_run = 0;
      end
    end
    if (wr && ca == 16'h5203) m_tgt = int'(d);
    if (wr && ca == 16'h5204) m_en = d[7];
    if (rd && ca == 16'h5204) m_pend = 0;
    if (evt) begin
      if (!m_in_frame) begin
        m_in_frame = 1;
        m_scan = 0;
        m_pend = 0;
      end else begin
        m_scan = (m_scan + 1) % 256;
        if (old_tgt != 0 && m_scan == old_tgt) m_pend = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("irq", 32'(irq), 32'(m_pend & m_en));
    check("in_frame", 32'(in_frame), 32'(m_in_frame));
    check("scanline", 32'(scanline), 32'(m_scan));
    check("stat_dat", 32'(stat_dat), 32'(model_stat()));
  endtask

  // driver tasks
  task automatic step(input logic p, input logic [13:0] pa, input logic cyc,
                      input logic wr, input logic rd, input logic [15:0] ca,
                      input logic [7:0] d, input logic rst);
    ppu_rd_stb  = p;
    ppu_addr    = pa;
    cpu_cyc_stb = cyc;
    cpu_wr_stb  = wr;
    cpu_rd_stb  = rd;
    cpu_addr    = ca;
    cpu_dat     = d;
    map_rst     = rst;
    #1;
    check("stat_oe", 32'(stat_oe), 32'(ca == 16'h5204));
    if (rd && (ca == 16'h5204) && !rst) begin
      last_rd_dat = stat_dat;
      exp_q.push_back(model_stat());
      check("stat_rd", 32'(last_rd_dat), 32'(exp_q.pop_front()));
    end
    model_step(p, pa, cyc, wr, rd, ca, d, rst);
    @(posedge clk);
    #1;
    ppu_rd_stb  = 1'b0;
    cpu_cyc_stb = 1'b0;
    cpu_wr_stb  = 1'b0;
    cpu_rd_stb  = 1'b0;
    map_rst     = 1'b0;
    compare_all();
  endtask

  task automatic ppu_read(input logic [13:0] a);
    step(1'b1, a, 1'b0, 1'b0, 1'b0, 16'h8000, 8'h00, 1'b0);
  endtask

  task automatic cpu_cycle();
    step(1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 16'h8000, 8'h00, 1'b0);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    step(1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic cpu_read(input logic [15:0] a);
    step(1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, a, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 16'h8000, 8'h00, 1'b1);
  endtask

  task automatic scan_event(input logic [13:0] a);
    for (int k = 0; k < 3; k++) ppu_read(a);
  endtask

  // alternating addresses so each event's first read starts a fresh run
  task automatic events(input int n);
    for (int i = 0; i < n; i++) scan_event((i % 2) ? 14'h2FC1 : 14'h23C0);
  endtask

  initial begin
    ppu_rd_stb = 0; ppu_addr = 0; cpu_cyc_stb = 0; cpu_wr_stb = 0;
    cpu_rd_stb = 0; cpu_addr = 16'h8000; cpu_dat = 0; map_rst = 1;
    last_rd_dat = 0;
    pool[0] = 14'h2FC0; pool[1] = 14'h2FC0; pool[2] = 14'h2FC0;
    pool[3] = 14'h23C0; pool[4] = 14'h0000; pool[5] = 14'h3F00;

    do_reset();
    do_reset();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_stat", 32'(stat_dat), 32'h00);
    check("rst_scan", 32'(scanline), 32'd0);

    // 1: three identical NT reads enter the frame; a 4th gives no new event
    scan_event(14'h2FC0);
    check("t1_inf", 32'(in_frame), 32'd1);
    check("t1_scan", 32'(scanline), 32'd0);
    check("t1_irq", 32'(irq), 32'd0);
    ppu_read(14'h2FC0);
    check("t1_4th_scan", 32'(scanline), 32'd0);

    // 2: target 5, six events, read-clear
    do_reset();
    cpu_write(16'h5203, 8'd5);
    cpu_write(16'h5204, 8'h80);
    scan_event(14'h2FC0);
    events(4);
    check("t2_scan4", 32'(scanline), 32'd4);
    check("t2_irq_lo", 32'(irq), 32'd0);
    scan_event(14'h23C0);
    check("t2_irq_hi", 32'(irq), 32'd1);
    check("t2_scan5", 32'(scanline), 32'd5);
    cpu_read(16'h5204);
    check("t2_stat", 32'(last_rd_dat), 32'hC0);
    check("t2_irq_clr", 32'(irq), 32'd0);

    // 3: idle timeout and re-entry
    cpu_cycle();
    cpu_cycle();
    check("t3_inf_2cyc", 32'(in_frame), 32'd1);
    cpu_cycle();
    check("t3_inf_out", 32'(in_frame), 32'd0);
    check("t3_scan_keep", 32'(scanline), 32'd5);
    scan_event(14'h2FC0);
    check("t3_scan0", 32'(scanline), 32'd0);
    cpu_read(16'h5204);
    check("t3_stat", 32'(last_rd_dat), 32'h40);

    // 4: broken runs and non-NT reads give no event
    ppu_read(14'h2000); ppu_read(14'h2000); ppu_read(14'h2400);
    ppu_read(14'h2000); ppu_read(14'h2000);
    check("t4_nt_break", 32'(scanline), 32'd0);
    ppu_read(14'h0000); ppu_read(14'h0000); ppu_read(14'h0000);
    check("t4_non_nt", 32'(scanline), 32'd0);
    check("t4_inf", 32'(in_frame), 32'd1);

    // 5: target 0 never pends; wrap; set beats same-clk read-clear
    do_reset();
    cpu_write(16'h5204, 8'h80);
    scan_event(14'h2FC0);
    events(300);
    check("t5_wrap", 32'(scanline), 32'd44);
    check("t5_irq", 32'(irq), 32'd0);
    cpu_write(16'h5203, 8'd45);
    ppu_read(14'h2FC0);
    ppu_read(14'h2FC0);
    step(1'b1, 14'h2FC0, 1'b0, 1'b0, 1'b1, 16'h5204, 8'h00, 1'b0);
    check("t5_set_wins", 32'(irq), 32'd1);
    check("t5_scan45", 32'(scanline), 32'd45);

    // 6: reset mid-frame with irq high
    do_reset();
    cpu_write(16'h5203, 8'd40);
    cpu_write(16'h5204, 8'h80);
    scan_event(14'h2FC0);
    events(40);
    check("t6_scan40", 32'(scanline), 32'd40);
    check("t6_irq", 32'(irq), 32'd1);
    do_reset();
    check("t6_rst_irq", 32'(irq), 32'd0);
    check("t6_rst_inf", 32'(in_frame), 32'd0);
    check("t6_rst_scan", 32'(scanline), 32'd0);
    check("t6_rst_stat", 32'(stat_dat), 32'h00);
    scan_event(14'h2FC0);
    check("t6_reenter", 32'(in_frame), 32'd1);
    check("t6_reenter_scan", 32'(scanline), 32'd0);

    // randomized phase: alternating busy / idle PPU periods
    for (int i = 0; i < 3000; i++) begin
      r_busy = ((i / 200) % 2 == 0) ? 75 : 20;
      r_p    = ($urandom_range(0, 99) < r_busy);
      r_pa   = pool[$urandom_range(0, 5)];
      r_cyc  = ($urandom_range(0, 99) < 35);
      r_kind = $urandom_range(0, 99);
      r_wr   = (r_kind < 6);
      r_rd   = (r_kind >= 6) && (r_kind < 14);
      r_ca   = (r_kind < 14) ? ($urandom_range(0, 1) ? 16'h5203 : 16'h5204) : 16'h8000;
      r_d    = (r_ca == 16'h5203) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      r_rst  = ($urandom_range(0, 999) == 0);
      step(r_p, r_pa, r_cyc, r_wr, r_rd, r_ca, r_d, r_rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
